bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
//
// PURPOSE
//   Iterative binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Sits directly upstream of the BCD-to-excess-3 stage.
//   Accepts one unsigned binary word per transaction via a valid/ready handshake.
//   Returns DIGITS packed BCD digits, each of which feeds a 4-bit excess-3 converter.
//
// PARAMETERS
//   BIN_W   8   width of the unsigned binary input
//   DIGITS  3   number of BCD output digits
//               Must satisfy 10**DIGITS > 2**BIN_W - 1.
//               Elaboration fails ($error) if this does not hold.
//
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           bin_in holds a word to convert
//   in_ready   out  1           converter idle and able to accept a word
//   bin_in     in   BIN_W       unsigned binary operand
//   out_valid  out  1           bcd_out holds a finished result
//   out_ready  in   1           downstream consumes the result
//   bcd_out    out  4*DIGITS    packed BCD; digit k = bcd_out[4k+3:4k]; k=0 is the units digit
//   busy       out  1           high while the converter is in SHIFT
//
// BEHAVIOUR
//   Reset (rst high at a clk edge):
//     - state=IDLE, out_valid=0, busy=0, bcd_out=0; in_ready=1 in the next cycle.
//     - Any in-flight conversion is discarded; nothing is emitted for it.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//     - in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==SHIFT).
//   IDLE:
//     - On in_valid && in_ready, latch bin_in and load scratch = {4*DIGITS'b0, bin_in}.
//     - Set cnt = BIN_W, go to SHIFT.
//     - bin_in is sampled only at this accepting edge.
//   SHIFT: once per clk, scratch = shl1(adj(scratch)) and cnt = cnt-1.
//     - adj(): every 4-bit digit field >= 5 gets +3, all digits in parallel, in the same cycle.
//     - Leave SHIFT when cnt reaches 0: copy the BCD field to bcd_out, go to DONE.
//     - in_valid is ignored throughout SHIFT.
//   DONE:
//     - bcd_out and out_valid stay stable until out_ready is sampled high.
//     - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
//     - A new word can be accepted at the earliest one cycle later; there is no IDLE bypass.
//   Latency: out_valid rises exactly BIN_W clk edges after the accepting edge.
//   Throughput: one word per BIN_W+2 cycles when out_ready is held high.
//   bcd_out updates only on the SHIFT->DONE edge; it holds its last value in IDLE and SHIFT.
//   Width rules:
//     - cnt is $clog2(BIN_W+1) bits.
//     - scratch is 4*DIGITS+BIN_W bits.
//     - Every digit field is always <= 9 after adj() and shl1().
//   Simultaneous events: rst dominates in_valid and out_ready in the same cycle.
//   Unused high digits read 0; for example, 42 with DIGITS=3 gives 12'h042.
//
// TESTING
//   1. bin_in=0 accepted -> out_valid after 8 edges, bcd_out=12'h000.
//   2. bin_in=255 -> bcd_out=12'h255.
//      Each digit through the excess-3 stage gives 0101,1000,1000.
//   3. bin_in=99; out_ready low 5 cycles after out_valid
//      -> bcd_out=12'h099 held stable, in_ready=0, extra in_valid ignored.
//   4. rst pulsed at the 4th SHIFT cycle of bin_in=200
//      -> next cycle out_valid=0, bcd_out=0, in_ready=1; no result for 200.
//   5. in_valid held high with words 7,128,250 and out_ready=1
//      -> results 007,128,250 in order, each exactly 10 cycles apart.
//   6. BIN_W=10, DIGITS=4, bin_in=1023 -> 10 edges later bcd_out=16'h1023.
//      DIGITS=2 with BIN_W=8 fails elaboration.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter
//
// Purpose:
//   Converts one unsigned BIN_W-bit word per transaction into DIGITS packed
//   BCD digits using shift-and-add-3. A conversion takes BIN_W SHIFT cycles.
//   The result is then held in DONE until downstream takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   bin_in holds a word to convert
//   in_ready   converter idle and able to accept a word
//   bin_in     unsigned binary operand, sampled only at the accepting edge
//   out_valid  bcd_out holds a finished result
//   out_ready  downstream consumes the result
//   bcd_out    packed BCD, digit k = bcd_out[4k+3:4k], k=0 is units
//   busy       high while a conversion is shifting

module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SW    = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // The digit field must be able to hold the largest binary input.
  if ((64'(10) ** DIGITS) <= ((64'(1) << BIN_W) - 64'(1))) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [SW-1:0]      scratch_q;
  logic [SW-1:0]      scratch_adj;
  logic [SW-1:0]      scratch_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // Add-3 correction on every digit field in parallel, then shift left.
  // Only digits 5..9 are corrected, so each field stays <= 9 after the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[BIN_W+4*k +: 4] >= 4'd5) begin
        scratch_adj[BIN_W+4*k +: 4] = scratch_q[BIN_W+4*k +: 4] + 4'd3;
      end
    end
    scratch_d = scratch_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            scratch_q  <= {{BCD_W{1'b0}}, bin_in};
            cnt_q      <= CNT_W'(BIN_W);
            state_q    <= S_SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_SHIFT: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          // Last shift: publish the digit field straight from the next value.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q       <= scratch_d[SW-1:BIN_W];
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  bin_in;
  logic        in_ready, out_valid, busy;
  logic [11:0] bcd_out;

  logic        in_valid2, out_ready2;
  logic [9:0]  bin_in2;
  logic        in_ready2, out_valid2, busy2;
  logic [15:0] bcd_out2;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .busy(busy)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .bin_in(bin_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bcd_out(bcd_out2), .busy(busy2)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [11:0] exp_q[$];
  int          acc_q[$];
  int          rise_q[$];
  logic        ov_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [11:0] bcd_model(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: latency of each result and scoreboard compare at every handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !ov_prev) begin
        rise_q.push_back(cyc);
        if (acc_q.size() == 0) fail_now("latency: out_valid with no accepted word");
        else check("latency", 32'(cyc - acc_q.pop_front()), 32'd8);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("bcd_out: unexpected result");
        else check("bcd_out", 32'(bcd_out), 32'(exp_q.pop_front()));
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [7:0] v, input logic [11:0] e);
    int t;
    in_valid = 1'b1;
    bin_in   = v;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) fail_now("send timeout");
    else exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[12];
    logic [7:0]  stream[3];
    logic [9:0]  wide_bin[3];
    logic [15:0] wide_bcd[3];
    int          t, acc;

    tbl[0]  = '{8'd0,   12'h000};
    tbl[1]  = '{8'd255, 12'h255};
    tbl[2]  = '{8'd42,  12'h042};
    tbl[3]  = '{8'd1,   12'h001};
    tbl[4]  = '{8'd9,   12'h009};
    tbl[5]  = '{8'd10,  12'h010};
    tbl[6]  = '{8'd100, 12'h100};
    tbl[7]  = '{8'd199, 12'h199};
    tbl[8]  = '{8'd128, 12'h128};
    tbl[9]  = '{8'd5,   12'h005};
    tbl[10] = '{8'd250, 12'h250};
    tbl[11] = '{8'd59,  12'h059};
    stream[0] = 8'd7; stream[1] = 8'd128; stream[2] = 8'd250;
    wide_bin[0] = 10'd1023; wide_bcd[0] = 16'h1023;
    wide_bin[1] = 10'd1000; wide_bcd[1] = 16'h1000;
    wide_bin[2] = 10'd999;  wide_bcd[2] = 16'h0999;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bin_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; bin_in2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'd0);

    // Zero input, plus busy/in_ready during SHIFT.
    @(posedge clk); #1;
    send(8'd0, 12'h000);
    @(negedge clk);
    check("busy in shift", 32'(busy), 32'd1);
    check("in_ready in shift", 32'(in_ready), 32'd0);
    drain();

    for (int i = 0; i < 12; i++) send(tbl[i].bin, tbl[i].bcd);
    drain();

    for (int i = 0; i < 6; i++) begin
      int r;
      r = int'($urandom_range(255, 0));
      send(8'(r), bcd_model(r));
    end
    drain();

    // Backpressure: result held, extra in_valid ignored.
    out_ready = 1'b0;
    send(8'd99, 12'h099);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("hold timeout");
    @(posedge clk); #1;
    in_valid = 1'b1; bin_in = 8'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold bcd_out", 32'(bcd_out), 32'h099);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a conversion discards it.
    in_valid = 1'b1; bin_in = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst bcd_out", 32'(bcd_out), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    repeat (15) @(posedge clk);
    #1;

    // Back-to-back words with in_valid held high.
    rise_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bin_in = stream[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 50);
      if (!in_ready) fail_now("stream timeout");
      else exp_q.push_back(bcd_model(int'(stream[i])));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream results", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("stream spacing 1", 32'(rise_q[1] - rise_q[0]), 32'd10);
      check("stream spacing 2", 32'(rise_q[2] - rise_q[1]), 32'd10);
    end

    // Wider instance: BIN_W=10, DIGITS=4.
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1; bin_in2 = wide_bin[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready2 && t < 50);
      acc = cyc + 1;
      @(posedge clk); #1 in_valid2 = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!out_valid2 && t < 50);
      if (!out_valid2) fail_now("wide timeout");
      else begin
        check("wide latency", 32'(cyc - acc), 32'd10);
        check("wide bcd_out", 32'(bcd_out2), 32'(wide_bcd[i]));
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

endmodule
